// File: rtl/tmr_voter_pkg.sv
// Shared types and the bitwise majority function for the word voter monitor.
package tmr_voter_pkg;

  localparam int unsigned RUN_WIDTH = 8;
  localparam int unsigned MAX_K     = 5;
  localparam int unsigned MAX_WIDTH = 64;

  typedef enum logic [1:0] {
    OK      = 2'd0,
    SUSPECT = 2'd1,
    FAULTY  = 2'd2
  } replica_state_t;

  typedef logic [MAX_K-1:0][MAX_WIDTH-1:0] word_array_t;

  // Replicas at index >= k are ignored; callers zero-pad unused slots and bits.
  function automatic logic [MAX_WIDTH-1:0] maj_vote(input int unsigned k,
                                                    input word_array_t words);
    logic [MAX_WIDTH-1:0] vote;
    int unsigned          ones;
    vote = '0;
    for (int unsigned b = 0; b < MAX_WIDTH; b++) begin
      ones = 0;
      for (int unsigned r = 0; r < MAX_K; r++) begin
        if (r < k) ones = ones + 32'(words[r][b]);
      end
      vote[b] = (ones > (k / 2));
    end
    return vote;
  endfunction

endpackage

// File: rtl/tmr_word_voter_monitor_health.sv
// Per-replica health tracker: saturating mismatch counter plus OK/SUSPECT/FAULTY escalation.
module replica_health_fsm
  import tmr_voter_pkg::*;
#(
  parameter int unsigned CNT_WIDTH      = 16,
  parameter int unsigned PERSIST_CYCLES = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 valid,
  input  logic                 dis,
  input  logic                 clear,
  output logic [CNT_WIDTH-1:0] cnt,
  output logic                 fault,
  output logic                 fault_enter
);

  localparam logic [RUN_WIDTH-1:0] RUN_LIMIT = RUN_WIDTH'(PERSIST_CYCLES);
  localparam logic [RUN_WIDTH-1:0] RUN_ONE   = RUN_WIDTH'(1);

  replica_state_t       state_q, state_d;
  logic [RUN_WIDTH-1:0] run_q, run_d, run_inc;
  logic [CNT_WIDTH-1:0] cnt_d;
  logic                 enter_d;

  assign run_inc = run_q + RUN_ONE;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= OK;
      run_q       <= '0;
      cnt         <= '0;
      fault_enter <= 1'b0;
    end else begin
      state_q     <= state_d;
      run_q       <= run_d;
      cnt         <= cnt_d;
      fault_enter <= enter_d;
    end
  end

  // Clear takes priority over a valid sample, so a clear also swallows the entry pulse.
  always_comb begin
    state_d = state_q;
    run_d   = run_q;
    cnt_d   = cnt;
    enter_d = 1'b0;
    if (clear) begin
      state_d = OK;
      run_d   = '0;
      cnt_d   = '0;
    end else if (valid) begin
      if (dis && (cnt != '1)) cnt_d = cnt + CNT_WIDTH'(1);
      case (state_q)
        OK: begin
          if (dis) begin
            run_d = RUN_ONE;
            if (RUN_LIMIT == RUN_ONE) begin
              state_d = FAULTY;
              enter_d = 1'b1;
            end else begin
              state_d = SUSPECT;
            end
          end
        end
        SUSPECT: begin
          if (dis) begin
            run_d = run_inc;
            if (run_inc == RUN_LIMIT) begin
              state_d = FAULTY;
              enter_d = 1'b1;
            end
          end else begin
            state_d = OK;
            run_d   = '0;
          end
        end
        FAULTY:  state_d = FAULTY;
        default: state_d = OK;
      endcase
    end
  end

  assign fault = (state_q == FAULTY);

endmodule

// File: rtl/tmr_word_voter_monitor.sv
// Registered K-way bitwise word voter with per-replica mismatch accounting and fault escalation.
module tmr_word_voter_monitor
  import tmr_voter_pkg::*;
#(
  parameter int unsigned K_MMR          = 3,
  parameter int unsigned WIDTH          = 8,
  parameter int unsigned CNT_WIDTH      = 16,
  parameter int unsigned PERSIST_CYCLES = 4
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 valid_i,
  input  logic [WIDTH-1:0]     data_i [K_MMR-1:0],
  input  logic                 clear_i,
  output logic [WIDTH-1:0]     data_o,
  output logic                 valid_o,
  output logic                 mismatch_o,
  output logic [K_MMR-1:0]     mismatch_replica_o,
  output logic [CNT_WIDTH-1:0] mismatch_cnt_o [K_MMR-1:0],
  output logic [K_MMR-1:0]     persistent_fault_o,
  output logic                 fault_irq_o
);

  if (!((K_MMR == 3) || (K_MMR == 5))) begin : g_bad_k
    $error("tmr_word_voter_monitor: K_MMR must be 3 or 5");
  end
  if ((WIDTH < 1) || (WIDTH > MAX_WIDTH)) begin : g_bad_width
    $error("tmr_word_voter_monitor: WIDTH out of range");
  end
  if ((PERSIST_CYCLES < 1) || (PERSIST_CYCLES > 255)) begin : g_bad_persist
    $error("tmr_word_voter_monitor: PERSIST_CYCLES must be 1..255");
  end

  word_array_t      words;
  logic [WIDTH-1:0] vote;
  logic [K_MMR-1:0] dis;
  logic [K_MMR-1:0] fault_enter;

  always_comb begin
    words = '0;
    for (int unsigned r = 0; r < K_MMR; r++) words[r] = MAX_WIDTH'(data_i[r]);
  end

  assign vote = WIDTH'(maj_vote(K_MMR, words));

  always_comb begin
    dis = '0;
    for (int unsigned r = 0; r < K_MMR; r++) dis[r] = (data_i[r] != vote);
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      valid_o            <= 1'b0;
      data_o             <= '0;
      mismatch_o         <= 1'b0;
      mismatch_replica_o <= '0;
    end else begin
      valid_o <= valid_i;
      if (valid_i) begin
        data_o             <= vote;
        mismatch_o         <= |dis;
        mismatch_replica_o <= dis;
      end
    end
  end

  for (genvar r = 0; r < K_MMR; r++) begin : g_health
    replica_health_fsm #(
      .CNT_WIDTH      (CNT_WIDTH),
      .PERSIST_CYCLES (PERSIST_CYCLES)
    ) u_fsm (
      .clk         (clk_i),
      .rst         (rst_i),
      .valid       (valid_i),
      .dis         (dis[r]),
      .clear       (clear_i),
      .cnt         (mismatch_cnt_o[r]),
      .fault       (persistent_fault_o[r]),
      .fault_enter (fault_enter[r])
    );
  end

  assign fault_irq_o = |fault_enter;

endmodule

// File: tb/tb_tmr_word_voter_monitor.sv
// Self-checking bench: a K=3 and a K=5 instance against a streak/saturation reference model.
module tb_tmr_word_voter_monitor;

  localparam int P3 = 4;
  localparam int P5 = 3;
  localparam int C3_MAX = 65535;
  localparam int C5_MAX = 15;

  logic clk = 1'b0;
  logic rst;
  logic v3, c3, v5, c5;
  logic [7:0] d3 [2:0];
  logic [7:0] d5 [4:0];

  logic [7:0]  o3_data, o5_data;
  logic        o3_valid, o5_valid, o3_mis, o5_mis, o3_irq, o5_irq;
  logic [2:0]  o3_misr, o3_fault;
  logic [4:0]  o5_misr, o5_fault;
  logic [15:0] o3_cnt [2:0];
  logic [3:0]  o5_cnt [4:0];

  int checks = 0;
  int failures = 0;

  // reference model state, index 0 = K3 instance, 1 = K5 instance
  int         m_cnt   [2][5];
  int         m_run   [2][5];
  bit         m_fault [2][5];
  logic [7:0] m_data  [2];
  bit         m_valid [2];
  bit         m_mis   [2];
  bit         m_irq   [2];
  bit   [4:0] m_misr  [2];

  always #5 clk = ~clk;

  tmr_word_voter_monitor #(
    .K_MMR(3), .WIDTH(8), .CNT_WIDTH(16), .PERSIST_CYCLES(P3)
  ) u3 (
    .clk_i(clk), .rst_i(rst), .valid_i(v3), .data_i(d3), .clear_i(c3),
    .data_o(o3_data), .valid_o(o3_valid), .mismatch_o(o3_mis),
    .mismatch_replica_o(o3_misr), .mismatch_cnt_o(o3_cnt),
    .persistent_fault_o(o3_fault), .fault_irq_o(o3_irq)
  );

  tmr_word_voter_monitor #(
    .K_MMR(5), .WIDTH(8), .CNT_WIDTH(4), .PERSIST_CYCLES(P5)
  ) u5 (
    .clk_i(clk), .rst_i(rst), .valid_i(v5), .data_i(d5), .clear_i(c5),
    .data_o(o5_data), .valid_o(o5_valid), .mismatch_o(o5_mis),
    .mismatch_replica_o(o5_misr), .mismatch_cnt_o(o5_cnt),
    .persistent_fault_o(o5_fault), .fault_irq_o(o5_irq)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 2; i++) begin
      m_data[i] = '0; m_valid[i] = 0; m_mis[i] = 0; m_irq[i] = 0; m_misr[i] = '0;
      for (int r = 0; r < 5; r++) begin
        m_cnt[i][r] = 0; m_run[i][r] = 0; m_fault[i][r] = 0;
      end
    end
  endtask

  task automatic model_inst(input int i, input int k, input int cmax, input int p,
                            input logic v, input logic clr, input logic [7:0] w [5]);
    logic [7:0] vote;
    bit   [4:0] dis;
    bit         newf;
    int         ones;
    vote = '0;
    dis  = '0;
    newf = 0;
    for (int b = 0; b < 8; b++) begin
      ones = 0;
      for (int r = 0; r < k; r++) ones += int'(w[r][b]);
      vote[b] = (2 * ones > k);
    end
    for (int r = 0; r < k; r++) dis[r] = (w[r] != vote);
    m_valid[i] = v;
    if (v) begin
      m_data[i] = vote;
      m_misr[i] = dis;
      m_mis[i]  = (dis != 0);
    end
    if (clr) begin
      for (int r = 0; r < 5; r++) begin
        m_cnt[i][r] = 0; m_run[i][r] = 0; m_fault[i][r] = 0;
      end
    end else if (v) begin
      for (int r = 0; r < k; r++) begin
        if (dis[r]) begin
          if (m_cnt[i][r] < cmax) m_cnt[i][r]++;
          if (!m_fault[i][r]) begin
            m_run[i][r]++;
            if (m_run[i][r] >= p) begin
              m_fault[i][r] = 1;
              newf = 1;
            end
          end
        end else if (!m_fault[i][r]) begin
          m_run[i][r] = 0;
        end
      end
    end
    m_irq[i] = newf;
  endtask

  task automatic model_update();
    logic [7:0] w [5];
    if (rst) begin
      model_reset();
    end else begin
      for (int r = 0; r < 5; r++) w[r] = (r < 3) ? d3[r] : 8'h00;
      model_inst(0, 3, C3_MAX, P3, v3, c3, w);
      for (int r = 0; r < 5; r++) w[r] = d5[r];
      model_inst(1, 5, C5_MAX, P5, v5, c5, w);
    end
  endtask

  task automatic check_all();
    logic [4:0] f3, f5;
    f3 = '0; f5 = '0;
    for (int r = 0; r < 5; r++) begin
      f3[r] = (r < 3) ? m_fault[0][r] : 1'b0;
      f5[r] = m_fault[1][r];
    end
    chk("u3.valid_o", 32'(o3_valid), 32'(m_valid[0]));
    chk("u3.data_o", 32'(o3_data), 32'(m_data[0]));
    chk("u3.mismatch_o", 32'(o3_mis), 32'(m_mis[0]));
    chk("u3.mismatch_replica_o", 32'(o3_misr), 32'(m_misr[0]));
    chk("u3.persistent_fault_o", 32'(o3_fault), 32'(f3));
    chk("u3.fault_irq_o", 32'(o3_irq), 32'(m_irq[0]));
    for (int r = 0; r < 3; r++)
      chk($sformatf("u3.cnt[%0d]", r), 32'(o3_cnt[r]), 32'(m_cnt[0][r]));
    chk("u5.valid_o", 32'(o5_valid), 32'(m_valid[1]));
    chk("u5.data_o", 32'(o5_data), 32'(m_data[1]));
    chk("u5.mismatch_o", 32'(o5_mis), 32'(m_mis[1]));
    chk("u5.mismatch_replica_o", 32'(o5_misr), 32'(m_misr[1]));
    chk("u5.persistent_fault_o", 32'(o5_fault), 32'(f5));
    chk("u5.fault_irq_o", 32'(o5_irq), 32'(m_irq[1]));
    for (int r = 0; r < 5; r++)
      chk($sformatf("u5.cnt[%0d]", r), 32'(o5_cnt[r]), 32'(m_cnt[1][r]));
  endtask

  task automatic cycle();
    @(posedge clk);
    model_update();
    #1;
    check_all();
  endtask

  task automatic set3(input logic [7:0] a0, input logic [7:0] a1, input logic [7:0] a2);
    d3[0] = a0; d3[1] = a1; d3[2] = a2;
  endtask

  task automatic set5(input logic [7:0] a0, input logic [7:0] a1, input logic [7:0] a2,
                      input logic [7:0] a3, input logic [7:0] a4);
    d5[0] = a0; d5[1] = a1; d5[2] = a2; d5[3] = a3; d5[4] = a4;
  endtask

  typedef struct {
    logic [23:0] d;      // {replica2, replica1, replica0}
    logic        v;
    logic        clr;
    logic [7:0]  exp_data;
    logic [2:0]  exp_misr;
    logic        exp_valid;
  } vec_t;

  vec_t tbl [6];

  initial begin
    logic [7:0] base, w;
    tbl[0] = '{24'hA5A5A5, 1'b1, 1'b0, 8'hA5, 3'b000, 1'b1};
    tbl[1] = '{24'hFFFF00, 1'b1, 1'b0, 8'hFF, 3'b001, 1'b1};
    tbl[2] = '{24'h0FF03C, 1'b1, 1'b0, 8'h3C, 3'b110, 1'b1};
    tbl[3] = '{24'h000000, 1'b0, 1'b0, 8'h3C, 3'b110, 1'b0};
    tbl[4] = '{24'h81817E, 1'b1, 1'b0, 8'h81, 3'b001, 1'b1};
    tbl[5] = '{24'h123412, 1'b1, 1'b1, 8'h12, 3'b010, 1'b1};

    rst = 1'b1; v3 = 0; c3 = 0; v5 = 0; c5 = 0;
    set3(8'h00, 8'h00, 8'h00);
    set5(8'h00, 8'h00, 8'h00, 8'h00, 8'h00);
    model_reset();
    repeat (2) cycle();
    chk("reset u3.data_o", 32'(o3_data), 32'h0);
    chk("reset u3.valid_o", 32'(o3_valid), 32'h0);
    chk("reset u5.fault", 32'(o5_fault), 32'h0);
    @(negedge clk);
    rst = 1'b0;

    // table-driven vectors on the K=3 instance
    for (int i = 0; i < 6; i++) begin
      set3(tbl[i].d[7:0], tbl[i].d[15:8], tbl[i].d[23:16]);
      v3 = tbl[i].v;
      c3 = tbl[i].clr;
      cycle();
      chk($sformatf("tbl%0d data_o", i), 32'(o3_data), 32'(tbl[i].exp_data));
      chk($sformatf("tbl%0d mismatch_replica_o", i), 32'(o3_misr), 32'(tbl[i].exp_misr));
      chk($sformatf("tbl%0d valid_o", i), 32'(o3_valid), 32'(tbl[i].exp_valid));
    end
    c3 = 0;
    chk("tbl clear cnt[1]", 32'(o3_cnt[1]), 32'h0);

    // all-agree sample, K=3; divergent sample, K=5
    set3(8'hA5, 8'hA5, 8'hA5); v3 = 1;
    set5(8'h0F, 8'h0F, 8'hF0, 8'h0F, 8'hFF); v5 = 1;
    cycle();
    chk("agree data_o", 32'(o3_data), 32'hA5);
    chk("agree mismatch_o", 32'(o3_mis), 32'h0);
    chk("agree cnt[1]", 32'(o3_cnt[1]), 32'h0);
    chk("k5 data_o", 32'(o5_data), 32'h0F);
    chk("k5 mismatch_replica_o", 32'(o5_misr), 32'b10100);
    chk("k5 cnt[2]", 32'(o5_cnt[2]), 32'h1);
    chk("k5 cnt[4]", 32'(o5_cnt[4]), 32'h1);
    v5 = 0;

    // escalation on replica 1 with a recovery in between
    set3(8'hA5, 8'hA4, 8'hA5);
    repeat (3) cycle();
    chk("susp mismatch_replica_o", 32'(o3_misr), 32'b010);
    chk("susp cnt[1]", 32'(o3_cnt[1]), 32'd3);
    chk("susp fault", 32'(o3_fault), 32'h0);
    set3(8'hA5, 8'hA5, 8'hA5);
    cycle();
    set3(8'hA5, 8'hA4, 8'hA5);
    for (int i = 0; i < 4; i++) begin
      cycle();
      if (i < 3) chk("pre-fault irq", 32'(o3_irq), 32'h0);
    end
    chk("fault flag", 32'(o3_fault), 32'b010);
    chk("fault irq", 32'(o3_irq), 32'h1);
    chk("fault cnt[1]", 32'(o3_cnt[1]), 32'd7);
    v3 = 0;
    cycle();
    chk("irq single pulse", 32'(o3_irq), 32'h0);
    chk("fault sticky", 32'(o3_fault), 32'b010);

    // clear with a mismatching valid sample while FAULTY
    set3(8'h5A, 8'h5A, 8'h5B); v3 = 1; c3 = 1;
    cycle();
    chk("clr fault", 32'(o3_fault), 32'h0);
    chk("clr cnt[1]", 32'(o3_cnt[1]), 32'h0);
    chk("clr cnt[2]", 32'(o3_cnt[2]), 32'h0);
    chk("clr irq", 32'(o3_irq), 32'h0);
    chk("clr data_o", 32'(o3_data), 32'h5A);
    chk("clr mismatch_replica_o", 32'(o3_misr), 32'b100);
    c3 = 0;

    // clear on the would-be FAULTY edge suppresses the pulse
    set3(8'hA5, 8'hA4, 8'hA5);
    repeat (3) cycle();
    c3 = 1;
    cycle();
    chk("supp irq", 32'(o3_irq), 32'h0);
    chk("supp fault", 32'(o3_fault), 32'h0);
    c3 = 0; v3 = 0;

    // K=5 counter saturation at 15
    c5 = 1;
    cycle();
    c5 = 0;
    set5(8'h00, 8'h00, 8'hFF, 8'h00, 8'h00); v5 = 1;
    repeat (20) cycle();
    chk("sat cnt[2]", 32'(o5_cnt[2]), 32'd15);
    chk("sat fault", 32'(o5_fault), 32'b00100);
    v5 = 0;

    // randomized traffic against the model
    for (int n = 0; n < 400; n++) begin
      base = 8'($urandom);
      for (int r = 0; r < 3; r++) begin
        w = base;
        if ($urandom_range(0, 99) < ((r == 0) ? 50 : 12)) w = w ^ 8'($urandom_range(1, 255));
        d3[r] = w;
      end
      for (int r = 0; r < 5; r++) begin
        w = base;
        if ($urandom_range(0, 99) < ((r == 3) ? 45 : 15)) w = w ^ 8'($urandom_range(1, 255));
        d5[r] = w;
      end
      v3 = ($urandom_range(0, 3) != 0);
      v5 = ($urandom_range(0, 3) != 0);
      c3 = ($urandom_range(0, 99) < 3);
      c5 = ($urandom_range(0, 99) < 3);
      cycle();
    end

    // asynchronous reset in the middle of a cycle
    set3(8'h11, 8'h22, 8'h11); v3 = 1; c3 = 0;
    set5(8'h33, 8'h33, 8'h44, 8'h33, 8'h55); v5 = 1; c5 = 0;
    cycle();
    #3 rst = 1'b1;
    #1;
    chk("async u3.data_o", 32'(o3_data), 32'h0);
    chk("async u3.valid_o", 32'(o3_valid), 32'h0);
    chk("async u3.cnt[1]", 32'(o3_cnt[1]), 32'h0);
    chk("async u3.fault", 32'(o3_fault), 32'h0);
    chk("async u5.mismatch_replica_o", 32'(o5_misr), 32'h0);
    chk("async u5.cnt[4]", 32'(o5_cnt[4]), 32'h0);
    model_reset();
    repeat (2) cycle();
    @(negedge clk);
    rst = 1'b0; v3 = 0; v5 = 0;
    cycle();
    chk("post-rst data_o", 32'(o3_data), 32'h0);
    v3 = 1;
    cycle();
    chk("post-rst first data_o", 32'(o3_data), 32'h11);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
